// File: rtl/instruction_decode_pkg.sv
// rtl/instruction_decode_pkg.sv - shared opcodes, control-bundle layout and decode helper
package instruction_decode_pkg;

  localparam int CTRL_WIDTH       = 9;
  localparam int CTRL_REG_WRITE   = 8;
  localparam int CTRL_MEM_READ    = 7;
  localparam int CTRL_MEM_WRITE   = 6;
  localparam int CTRL_MEM_TO_REG  = 5;
  localparam int CTRL_ALU_SRC     = 4;
  localparam int CTRL_REG_DST     = 3;
  localparam int CTRL_BRANCH      = 2;
  localparam int CTRL_ALUOP_MSB   = 1;
  localparam int CTRL_ALUOP_LSB   = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // The all-zero word shares opcode 0 with R-type, so it is filtered out first.
  function automatic logic [CTRL_WIDTH-1:0] decode_control(input logic [31:0] instr);
    logic [CTRL_WIDTH-1:0] c;
    c = '0;
    if (instr != NOP_INSTR) begin
      case (instr[31:26])
        OP_RTYPE: begin
          c[CTRL_REG_WRITE] = 1'b1;
          c[CTRL_REG_DST]   = 1'b1;
          c[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALUOP_FUNCT;
        end
        OP_LW: begin
          c[CTRL_REG_WRITE]  = 1'b1;
          c[CTRL_MEM_READ]   = 1'b1;
          c[CTRL_MEM_TO_REG] = 1'b1;
          c[CTRL_ALU_SRC]    = 1'b1;
          c[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALUOP_ADD;
        end
        OP_SW: begin
          c[CTRL_MEM_WRITE] = 1'b1;
          c[CTRL_ALU_SRC]   = 1'b1;
          c[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALUOP_ADD;
        end
        OP_BEQ: begin
          c[CTRL_BRANCH] = 1'b1;
          c[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALUOP_SUB;
        end
        OP_ADDI: begin
          c[CTRL_REG_WRITE] = 1'b1;
          c[CTRL_ALU_SRC]   = 1'b1;
          c[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = ALUOP_ADD;
        end
        default: c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// rtl/instruction_decode_register_file.sv - 2R/1W register file, r0 hardwired to zero,
// same-cycle write-to-read bypass
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr1,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr2,
  output logic [DATA_WIDTH-1:0] o_rd_data1,
  output logic [DATA_WIDTH-1:0] o_rd_data2,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data
);

  logic [DATA_WIDTH-1:0] r_regs [2**ADDR_WIDTH];
  logic                  w_wr_valid;

  assign w_wr_valid = i_wr_en && (i_wr_addr != '0);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_regs <= '{default: '0};
    end else if (w_wr_valid) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data1 = '0;
    o_rd_data2 = '0;
    if (i_rd_addr1 != '0) begin
      o_rd_data1 = (w_wr_valid && i_wr_addr == i_rd_addr1) ? i_wr_data : r_regs[i_rd_addr1];
    end
    if (i_rd_addr2 != '0) begin
      o_rd_data2 = (w_wr_valid && i_wr_addr == i_rd_addr2) ? i_wr_data : r_regs[i_rd_addr2];
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - pipeline decode stage: control decode, register file,
// load-use hazard stall and ID/EX register
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     programCounterIn,
  input  logic [31:0]               instruction,
  input  logic                      regWriteEnable,
  input  logic [REG_ADDR_WIDTH-1:0] regWriteAddress,
  input  logic [DATA_WIDTH-1:0]     regWriteData,
  output logic                      pcWrite,
  output logic                      ifIdWrite,
  output logic [DATA_WIDTH-1:0]     idExPc,
  output logic [DATA_WIDTH-1:0]     idExReadData1,
  output logic [DATA_WIDTH-1:0]     idExReadData2,
  output logic [DATA_WIDTH-1:0]     idExImmediate,
  output logic [REG_ADDR_WIDTH-1:0] idExRs,
  output logic [REG_ADDR_WIDTH-1:0] idExRt,
  output logic [REG_ADDR_WIDTH-1:0] idExRd,
  output logic [CTRL_WIDTH-1:0]     idExControl
);

  logic [REG_ADDR_WIDTH-1:0] w_rs;
  logic [REG_ADDR_WIDTH-1:0] w_rt;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0]     w_read_data1;
  logic [DATA_WIDTH-1:0]     w_read_data2;
  logic [DATA_WIDTH-1:0]     w_immediate;
  logic [CTRL_WIDTH-1:0]     w_control;
  logic                      w_stall;

  assign w_rs        = instruction[25:21];
  assign w_rt        = instruction[20:16];
  assign w_rd        = instruction[15:11];
  assign w_immediate = {{(DATA_WIDTH-16){instruction[15]}}, instruction[15:0]};
  assign w_control   = decode_control(instruction);

  register_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_register_file (
    .clk        (clk),
    .i_reset    (reset),
    .i_rd_addr1 (w_rs),
    .i_rd_addr2 (w_rt),
    .o_rd_data1 (w_read_data1),
    .o_rd_data2 (w_read_data2),
    .i_wr_en    (regWriteEnable),
    .i_wr_addr  (regWriteAddress),
    .i_wr_data  (regWriteData)
  );

  // The bubble clears memRead, so a load-use stall never lasts more than one cycle.
  assign w_stall = idExControl[CTRL_MEM_READ] && (idExRt != '0) &&
                   ((idExRt == w_rs) || (idExRt == w_rt));

  assign pcWrite   = !reset && !w_stall;
  assign ifIdWrite = !reset && !w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      idExPc        <= '0;
      idExReadData1 <= '0;
      idExReadData2 <= '0;
      idExImmediate <= '0;
      idExRs        <= '0;
      idExRt        <= '0;
      idExRd        <= '0;
      idExControl   <= '0;
    end else begin
      idExPc        <= programCounterIn;
      idExReadData1 <= w_read_data1;
      idExReadData2 <= w_read_data2;
      idExImmediate <= w_immediate;
      idExRs        <= w_rs;
      idExRt        <= w_rt;
      idExRd        <= w_rd;
      idExControl   <= w_stall ? '0 : w_control;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - scoreboard bench for the decode stage
module tb_instruction_decode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [8:0]  ctrl;
  } exp_t;

  localparam logic [8:0] C_RTYPE = 9'h10A;
  localparam logic [8:0] C_LW    = 9'h1B0;
  localparam logic [8:0] C_SW    = 9'h050;
  localparam logic [8:0] C_BEQ   = 9'h005;
  localparam logic [8:0] C_ADDI  = 9'h110;

  localparam logic [31:0] I_ADDI_R6_R5_M4 = 32'h20A6FFFC;
  localparam logic [31:0] I_ADD_R8_R7_R7  = 32'h00E74020;
  localparam logic [31:0] I_LW_R2_0_R1    = 32'h8C220000;
  localparam logic [31:0] I_ADD_R3_R2_R4  = 32'h00441820;
  localparam logic [31:0] I_LW_R0_0_R1    = 32'h8C200000;
  localparam logic [31:0] I_ADD_R9_R0_R0  = 32'h00004820;
  localparam logic [31:0] I_OP3F          = 32'hFC000000;
  localparam logic [31:0] I_SW_R4_8_R1    = 32'hAC240008;
  localparam logic [31:0] I_BEQ_R1_R4_M1  = 32'h1024FFFF;
  localparam logic [31:0] I_LW_R2_4_R1    = 32'h8C220004;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] programCounterIn;
  logic [31:0] instruction;
  logic        regWriteEnable;
  logic [4:0]  regWriteAddress;
  logic [31:0] regWriteData;
  logic        pcWrite;
  logic        ifIdWrite;
  logic [31:0] idExPc;
  logic [31:0] idExReadData1;
  logic [31:0] idExReadData2;
  logic [31:0] idExImmediate;
  logic [4:0]  idExRs;
  logic [4:0]  idExRt;
  logic [4:0]  idExRd;
  logic [8:0]  idExControl;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk              (clk),
    .reset            (reset),
    .programCounterIn (programCounterIn),
    .instruction      (instruction),
    .regWriteEnable   (regWriteEnable),
    .regWriteAddress  (regWriteAddress),
    .regWriteData     (regWriteData),
    .pcWrite          (pcWrite),
    .ifIdWrite        (ifIdWrite),
    .idExPc           (idExPc),
    .idExReadData1    (idExReadData1),
    .idExReadData2    (idExReadData2),
    .idExImmediate    (idExImmediate),
    .idExRs           (idExRs),
    .idExRt           (idExRt),
    .idExRd           (idExRd),
    .idExControl      (idExControl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [8:0] ctrl);
    exp_t e;
    e.pc   = pc;
    e.rd1  = rd1;
    e.rd2  = rd2;
    e.imm  = {{16{instr[15]}}, instr[15:0]};
    e.rs   = instr[25:21];
    e.rt   = instr[20:16];
    e.rd   = instr[15:11];
    e.ctrl = ctrl;
    return e;
  endfunction

  task automatic run_cycle(input string tag, input logic rst, input logic [31:0] pc,
                           input logic [31:0] instr, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic exp_pcw, input exp_t e);
    exp_t got;
    reset            = rst;
    programCounterIn = pc;
    instruction      = instr;
    regWriteEnable   = we;
    regWriteAddress  = wa;
    regWriteData     = wd;
    #1;
    check({tag, "_pcWrite"}, {31'd0, pcWrite}, {31'd0, exp_pcw});
    check({tag, "_ifIdWrite"}, {31'd0, ifIdWrite}, {31'd0, exp_pcw});
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s_queue: got empty scoreboard expected one entry", tag);
    end else begin
      got = exp_q.pop_front();
      check({tag, "_pc"},   idExPc,        got.pc);
      check({tag, "_rd1"},  idExReadData1, got.rd1);
      check({tag, "_rd2"},  idExReadData2, got.rd2);
      check({tag, "_imm"},  idExImmediate, got.imm);
      check({tag, "_rs"},   {27'd0, idExRs}, {27'd0, got.rs});
      check({tag, "_rt"},   {27'd0, idExRt}, {27'd0, got.rt});
      check({tag, "_rd"},   {27'd0, idExRd}, {27'd0, got.rd});
      check({tag, "_ctrl"}, {23'd0, idExControl}, {23'd0, got.ctrl});
    end
  endtask

  initial begin
    reset = 1'b1; programCounterIn = '0; instruction = '0;
    regWriteEnable = 1'b0; regWriteAddress = '0; regWriteData = '0;

    run_cycle("rst0", 1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, mk(32'h0, 32'h0, 0, 0, 9'h0));
    run_cycle("rst1", 1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, mk(32'h0, 32'h0, 0, 0, 9'h0));
    run_cycle("rel",  1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, mk(32'h0, 32'h0, 0, 0, 9'h0));

    run_cycle("wb_r5", 1'b0, 32'h4, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b1, mk(32'h4, 32'h0, 0, 0, 9'h0));
    run_cycle("wb_r1", 1'b0, 32'h8, 32'h0, 1'b1, 5'd1, 32'h100,  1'b1, mk(32'h8, 32'h0, 0, 0, 9'h0));
    run_cycle("addi",  1'b0, 32'hC, I_ADDI_R6_R5_M4, 1'b1, 5'd4, 32'h44, 1'b1,
              mk(32'hC, I_ADDI_R6_R5_M4, 32'h1234, 32'h0, C_ADDI));
    check("addi_imm_const", idExImmediate, 32'hFFFFFFFC);

    run_cycle("bypass", 1'b0, 32'h10, I_ADD_R8_R7_R7, 1'b1, 5'd7, 32'hDEAD, 1'b1,
              mk(32'h10, I_ADD_R8_R7_R7, 32'hDEAD, 32'hDEAD, C_RTYPE));

    run_cycle("lw",       1'b0, 32'h14, I_LW_R2_0_R1, 1'b0, 5'd0, 32'h0, 1'b1,
              mk(32'h14, I_LW_R2_0_R1, 32'h100, 32'h0, C_LW));
    run_cycle("stall",    1'b0, 32'h18, I_ADD_R3_R2_R4, 1'b1, 5'd2, 32'h77, 1'b0,
              mk(32'h18, I_ADD_R3_R2_R4, 32'h77, 32'h44, 9'h0));
    run_cycle("reissue",  1'b0, 32'h18, I_ADD_R3_R2_R4, 1'b0, 5'd0, 32'h0, 1'b1,
              mk(32'h18, I_ADD_R3_R2_R4, 32'h77, 32'h44, C_RTYPE));

    run_cycle("lw_r0",    1'b0, 32'h1C, I_LW_R0_0_R1, 1'b0, 5'd0, 32'h0, 1'b1,
              mk(32'h1C, I_LW_R0_0_R1, 32'h100, 32'h0, C_LW));
    run_cycle("use_r0",   1'b0, 32'h20, I_ADD_R9_R0_R0, 1'b1, 5'd0, 32'hFFFF, 1'b1,
              mk(32'h20, I_ADD_R9_R0_R0, 32'h0, 32'h0, C_RTYPE));
    run_cycle("op3f",     1'b0, 32'h24, I_OP3F, 1'b0, 5'd0, 32'h0, 1'b1,
              mk(32'h24, I_OP3F, 32'h0, 32'h0, 9'h0));
    run_cycle("sw",       1'b0, 32'h28, I_SW_R4_8_R1, 1'b0, 5'd0, 32'h0, 1'b1,
              mk(32'h28, I_SW_R4_8_R1, 32'h100, 32'h44, C_SW));
    run_cycle("beq",      1'b0, 32'h2C, I_BEQ_R1_R4_M1, 1'b0, 5'd0, 32'h0, 1'b1,
              mk(32'h2C, I_BEQ_R1_R4_M1, 32'h100, 32'h44, C_BEQ));

    run_cycle("lw2",      1'b0, 32'h30, I_LW_R2_4_R1, 1'b0, 5'd0, 32'h0, 1'b1,
              mk(32'h30, I_LW_R2_4_R1, 32'h100, 32'h77, C_LW));
    instruction      = I_ADD_R3_R2_R4;
    programCounterIn = 32'h34;
    #1;
    check("pre_rst_stall", {31'd0, pcWrite}, 32'd0);
    run_cycle("rst_mid",  1'b1, 32'h34, I_ADD_R3_R2_R4, 1'b0, 5'd0, 32'h0, 1'b0,
              mk(32'h0, 32'h0, 32'h0, 32'h0, 9'h0));
    run_cycle("post_rst", 1'b0, 32'h34, I_ADD_R3_R2_R4, 1'b0, 5'd0, 32'h0, 1'b1,
              mk(32'h34, I_ADD_R3_R2_R4, 32'h0, 32'h0, C_RTYPE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage of the 5-stage pipeline.
- Consumes the IF/ID register contents (programCounterOut, instruction) driven by the fetch stage.
- Returns pcWrite / ifIdWrite to the fetch stage for load-use stalls.
- Owns the 32x32 register file and drives the ID/EX pipeline register into execute.

Parameters:
- DATA_WIDTH, 32, width of registers, PC and immediates
- REG_ADDR_WIDTH, 5, register address width (2**5 = 32 registers)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- programCounterIn  input  32  PC of the instruction in IF/ID
- instruction  input  32  instruction word in IF/ID
- regWriteEnable  input  1  write-back enable from WB stage
- regWriteAddress  input  5  write-back destination register
- regWriteData  input  32  write-back data
- pcWrite  output  1  fetch PC advance enable (0 = stall)
- ifIdWrite  output  1  IF/ID load enable (0 = hold)
- idExPc  output  32  registered PC
- idExReadData1  output  32  registered rs value
- idExReadData2  output  32  registered rt value
- idExImmediate  output  32  registered sign-extended instruction[15:0]
- idExRs, idExRt, idExRd  output  5 each  registered instruction[25:21], [20:16], [15:11]
- idExControl  output  9  registered control, packed as {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, branch, aluOp[1:0]}

Behaviour:
- Reset
  - All ID/EX outputs and every register-file entry are cleared to 0.
  - pcWrite = 0 and ifIdWrite = 0 while reset is high.
  - Reset asserted mid-operation discards any pending stall.
- Opcode decode (instruction[31:26]); control bit order as in idExControl:
  - 0x00 R-type: regWrite, regDst, aluOp = 10.
  - 0x23 lw: regWrite, memRead, memToReg, aluSrc, aluOp = 00.
  - 0x2B sw: memWrite, aluSrc, aluOp = 00.
  - 0x04 beq: branch, aluOp = 01.
  - 0x08 addi: regWrite, aluSrc, aluOp = 00.
  - Any other opcode, and instruction == 0x00000000: all control bits 0 (nop).
- Register file
  - Write on the rising edge when regWriteEnable = 1 and regWriteAddress != 0.
  - Writes to r0 are ignored; reads of r0 always return 0.
  - Read ports are combinational, with an internal bypass: if regWriteEnable = 1, regWriteAddress != 0 and it equals the read address, the read returns regWriteData in the same cycle.
- Hazard detection (combinational)
  - stall = idExControl.memRead AND idExRt != 0 AND (idExRt == instruction[25:21] OR idExRt == instruction[20:16]).
  - pcWrite = ifIdWrite = NOT stall (when not in reset).
- ID/EX register, each rising edge:
  - If stall: load a bubble (idExControl = 0; data fields may load normally).
  - Else: load the decoded fields and control.
  - Latency: instruction in IF/ID appears on the ID/EX outputs one clock later.
- Stall length: a stall lasts exactly one cycle, because the bubble clears memRead. The held instruction re-decodes the next cycle and reads the forwarded/written-back value.
- Write-back during a stall is still performed.

Decomposition:
- Shared package:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  - control-bundle bit positions
  - ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT encodings
  - nop instruction constant
- Sub-module: register_file (2 read ports, 1 write port, r0 hardwired, bypass). Instantiated once; hazard logic and decode stay inline.

Test Plan:
- Reset held 2 cycles, then released with instruction = 0 → all ID/EX outputs 0; pcWrite = ifIdWrite = 1 after release.
- Write r5 = 0x1234 via WB, then decode addi r6,r5,-4 (0x20A6FFFC) → next cycle idExReadData1 = 0x1234, idExImmediate = 0xFFFFFFFC, idExControl has regWrite and aluSrc set.
- WB writes r7 = 0xDEAD in the same cycle add r8,r7,r7 is decoded → both read data = 0xDEAD (bypass).
- lw r2,0(r1) followed by add r3,r2,r4 → one cycle with pcWrite = ifIdWrite = 0, a bubble (control 0) in ID/EX, then the add issues with regWrite/regDst set.
- lw r0,... followed by add using r0 → no stall; write to r0 via WB with 0xFFFF → r0 still reads 0.
- Opcode 0x3F → control 0; reset pulsed during a load-use stall → outputs zeroed next edge, stall dropped.
